multi_key_debouncer: RTL

MULTI_KEY_DEBOUNCER -- requirements
Module: multi_key_debouncer

---
 rtl/multi_key_debouncer.sv | 98 +++++++++
 1 files changed

// File: rtl/multi_key_debouncer.sv
// Multi-channel key debouncer: 2-flop synchroniser + per-channel stability counter.
// Define KEY_EDGE_EN to enable press/release pulses and the key_valid/key_code encoder.
module multi_key_debouncer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CNT_MAX = 2_000_000,
  parameter int unsigned CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_db,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic             key_valid,
  output logic [4:0]       key_code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != key_db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Any sample agreeing with key_db discards the run; the counter tops out at CNT_LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == key_db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          key_db[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_EDGE_EN
  logic [4:0] lowest;

  always_comb begin
    lowest = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (key_press[i-1]) begin
        lowest = 5'(i - 1);
      end
    end
  end

  // Pulses are registered alongside key_db so they share its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_press   <= '0;
      key_release <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
    end else begin
      key_press   <= accept & sync2;
      key_release <= accept & ~sync2;
      key_valid   <= |key_press;
      if (|key_press) begin
        key_code <= lowest;
      end
    end
  end
`else
  assign key_press   = '0;
  assign key_release = '0;
  assign key_valid   = 1'b0;
  assign key_code    = '0;
`endif

endmodule
